vector_player: RTL

VECTOR_PLAYER -- requirements
Module: vector_player

---
 rtl/hack_tb_pkg.sv | 20 ++
 rtl/vector_player_sat_counter.sv | 37 +++
 rtl/vector_player.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hack_tb_pkg.sv
// Shared definitions for the vector player: vector word layout and the
// player state encoding.
package hack_tb_pkg;

    localparam int VEC_W       = 33;
    localparam int VEC_IN_MSB  = 32;
    localparam int VEC_IN_LSB  = 17;
    localparam int VEC_LOAD    = 16;
    localparam int VEC_EXP_MSB = 15;
    localparam int DATA_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vector_player_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vector_player.sv
// Plays NUM_VECTORS test vectors (3 cycles each) into a 16-bit Register and
// counts mismatches. Define VECTOR_PLAYER_CAPTURE_EN to add first-failure capture.
module vector_player
    import hack_tb_pkg::*;
#(
    parameter int NUM_VECTORS = 148,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic [VEC_W-1:0]  vec_data,
    output logic [DATA_W-1:0] dut_in,
    output logic              dut_load,
    input  logic [DATA_W-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] err_count
`ifdef VECTOR_PLAYER_CAPTURE_EN
    ,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_idx,
    output logic [DATA_W-1:0] fail_got,
    output logic [DATA_W-1:0] fail_exp
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VECTORS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] out_exp_q, out_exp_d;
    logic              run_start;
    logic              mismatch;
    logic              more_vectors;

    assign run_start    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign more_vectors = (idx_q < LAST_IDX);
    assign mismatch     = (state_q == ST_CHECK) && (dut_out != out_exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            out_exp_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            out_exp_q <= out_exp_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        out_exp_d = out_exp_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (run_start) begin
                state_d = ST_READ;
                idx_d   = '0;
            end
            ST_READ:  state_d = ST_LOAD;
            ST_LOAD: begin
                state_d   = ST_CHECK;
                out_exp_d = vec_data[VEC_EXP_MSB:0];
            end
            ST_CHECK: if (more_vectors) begin
                state_d = ST_READ;
                idx_d   = idx_q + ADDR_W'(1);
            end else begin
                state_d = ST_DONE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dut_in   = '0;
        dut_load = 1'b0;
        if (state_q == ST_LOAD) begin
            dut_in   = vec_data[VEC_IN_MSB:VEC_IN_LSB];
            dut_load = vec_data[VEC_LOAD];
        end
    end

    // The address is held from the index register in every state so the
    // memory sees a stable address for the whole 3-cycle vector slot.
    assign vec_addr = idx_q;
    assign busy     = (state_q == ST_READ) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign done     = (state_q == ST_DONE);
    assign pass     = done && (err_count == '0);

    sat_counter #(
        .W (DATA_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (run_start),
        .inc_i   (mismatch),
        .count_o (err_count)
    );

`ifdef VECTOR_PLAYER_CAPTURE_EN
    logic              fail_valid_q;
    logic [ADDR_W-1:0] fail_idx_q;
    logic [DATA_W-1:0] fail_got_q, fail_exp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
            fail_got_q   <= '0;
            fail_exp_q   <= '0;
        end else if (run_start) begin
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
            fail_got_q   <= '0;
            fail_exp_q   <= '0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_idx_q   <= idx_q;
            fail_got_q   <= dut_out;
            fail_exp_q   <= out_exp_q;
        end
    end

    assign fail_valid = fail_valid_q;
    assign fail_idx   = fail_idx_q;
    assign fail_got   = fail_got_q;
    assign fail_exp   = fail_exp_q;
`endif

endmodule
